// File: rtl/operaciones_pkg.sv
// Shared encodings for the arithmetic block: operation select codes and
// control-state enumeration.
package operaciones_pkg;

   localparam logic [1:0] MODO_SUMA  = 2'b00;
   localparam logic [1:0] MODO_RESTA = 2'b01;
   localparam logic [1:0] MODO_MULT  = 2'b10;
   localparam logic [1:0] MODO_DIV   = 2'b11;

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      CALCULO = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

endpackage

// File: rtl/divisor_restaurador.sv
// Unsigned restoring divider, one quotient bit per clock over WIDTH cycles.
// cociente/residuo show the value being produced on the edge where done is 1.
module divisor_restaurador
   import operaciones_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividendo,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] cociente,
   output logic [WIDTH-1:0] residuo
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;

   logic [WIDTH:0]   desplazado;
   logic [WIDTH-1:0] rem_paso;
   logic [WIDTH-1:0] quo_paso;
   logic             ultimo;

   always_comb begin
      // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
      desplazado = {rem_q, quo_q[WIDTH-1]};
      if (desplazado >= {1'b0, dsr_q}) begin
         rem_paso = desplazado[WIDTH-1:0] - dsr_q;
         quo_paso = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_paso = desplazado[WIDTH-1:0];
         quo_paso = {quo_q[WIDTH-2:0], 1'b0};
      end
      ultimo = busy_q && (cnt_q == CW'(WIDTH - 1));

      rem_d  = rem_q;
      quo_d  = quo_q;
      dsr_d  = dsr_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start) begin
         rem_d  = '0;
         quo_d  = dividendo;
         dsr_d  = divisor;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d = rem_paso;
         quo_d = quo_paso;
         cnt_d = cnt_q + CW'(1);
         if (ultimo) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dsr_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dsr_q  <= dsr_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign done     = ultimo;
   assign cociente = quo_paso;
   assign residuo  = rem_paso;

endmodule

// File: rtl/operacion_param.sv
// Two-operand handshaked arithmetic unit: add, subtract, iterative multiply
// and restoring divide, with result held until the consumer takes it.
module operacion_param
   import operaciones_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] operandoA,
   input  logic             validoA,
   output logic             ListoA,
   input  logic [WIDTH-1:0] operandoB,
   input  logic             validoB,
   output logic             ListoB,
   input  logic [1:0]       modo,
   output logic [WIDTH-1:0] salida,
   output logic [WIDTH-1:0] extra,
   output logic             error,
   output logic             ListoS,
   input  logic             tomado
);

   localparam int unsigned CW = $clog2(WIDTH);

   estado_t            estado_q, estado_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic               a_ok_q, a_ok_d, b_ok_q, b_ok_d;
   logic [1:0]         modo_q, modo_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   salida_q, salida_d, extra_q, extra_d;
   logic               error_q, error_d;

   logic               cap_a, cap_b;
   logic [WIDTH-1:0]   a_eff, b_eff;
   logic [WIDTH:0]     suma;
   logic [WIDTH:0]     mul_acum;
   logic [2*WIDTH-1:0] mul_sig;
   logic               div_start, div_busy, div_done;
   logic [WIDTH-1:0]   div_coc, div_res;

   divisor_restaurador #(.WIDTH(WIDTH)) u_div (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (div_start),
      .dividendo (a_eff),
      .divisor   (b_eff),
      .busy      (div_busy),
      .done      (div_done),
      .cociente  (div_coc),
      .residuo   (div_res)
   );

   always_comb begin
      estado_d  = estado_q;
      a_d       = a_q;
      b_d       = b_q;
      a_ok_d    = a_ok_q;
      b_ok_d    = b_ok_q;
      modo_d    = modo_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      salida_d  = salida_q;
      extra_d   = extra_q;
      error_d   = error_q;
      div_start = 1'b0;

      cap_a = (estado_q == ESPERA) && validoA && !a_ok_q;
      cap_b = (estado_q == ESPERA) && validoB && !b_ok_q;
      a_eff = a_ok_q ? a_q : operandoA;
      b_eff = b_ok_q ? b_q : operandoB;

      suma     = {1'b0, a_q} + {1'b0, b_q};
      // Shift-add step: add multiplicand into the high half when the low bit is set, then shift right.
      mul_acum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};
      mul_sig  = {mul_acum, prod_q[WIDTH-1:1]};

      unique case (estado_q)
         ESPERA: begin
            if (cap_a) begin
               a_d    = operandoA;
               a_ok_d = 1'b1;
            end
            if (cap_b) begin
               b_d    = operandoB;
               b_ok_d = 1'b1;
            end
            if ((a_ok_q || cap_a) && (b_ok_q || cap_b)) begin
               modo_d    = modo;
               cnt_d     = '0;
               prod_d    = {{WIDTH{1'b0}}, b_eff};
               div_start = (modo == MODO_DIV) && (b_eff != '0);
               estado_d  = CALCULO;
            end
         end
         CALCULO: begin
            unique case (modo_q)
               MODO_SUMA: begin
                  salida_d = suma[WIDTH-1:0];
                  extra_d  = WIDTH'(suma[WIDTH]);
                  error_d  = 1'b0;
                  estado_d = ENTREGA;
               end
               MODO_RESTA: begin
                  salida_d = a_q - b_q;
                  extra_d  = WIDTH'(a_q < b_q);
                  error_d  = 1'b0;
                  estado_d = ENTREGA;
               end
               MODO_MULT: begin
                  prod_d = mul_sig;
                  cnt_d  = cnt_q + CW'(1);
                  if (cnt_q == CW'(WIDTH - 1)) begin
                     salida_d = mul_sig[WIDTH-1:0];
                     extra_d  = mul_sig[2*WIDTH-1:WIDTH];
                     error_d  = 1'b0;
                     cnt_d    = '0;
                     estado_d = ENTREGA;
                  end
               end
               default: begin
                  if (b_q == '0) begin
                     salida_d = '1;
                     extra_d  = a_q;
                     error_d  = 1'b1;
                     estado_d = ENTREGA;
                  end else if (div_busy && div_done) begin
                     salida_d = div_coc;
                     extra_d  = div_res;
                     error_d  = 1'b0;
                     estado_d = ENTREGA;
                  end
               end
            endcase
         end
         ENTREGA: begin
            if (tomado) begin
               a_ok_d   = 1'b0;
               b_ok_d   = 1'b0;
               estado_d = ESPERA;
            end
         end
         default: estado_d = ESPERA;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= ESPERA;
         a_q      <= '0;
         b_q      <= '0;
         a_ok_q   <= 1'b0;
         b_ok_q   <= 1'b0;
         modo_q   <= MODO_SUMA;
         prod_q   <= '0;
         cnt_q    <= '0;
         salida_q <= '0;
         extra_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         a_q      <= a_d;
         b_q      <= b_d;
         a_ok_q   <= a_ok_d;
         b_ok_q   <= b_ok_d;
         modo_q   <= modo_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         salida_q <= salida_d;
         extra_q  <= extra_d;
         error_q  <= error_d;
      end
   end

   assign ListoA = (estado_q == ESPERA) && !a_ok_q;
   assign ListoB = (estado_q == ESPERA) && !b_ok_q;
   assign ListoS = (estado_q == ENTREGA);
   assign salida = salida_q;
   assign extra  = extra_q;
   assign error  = error_q;

endmodule
